apb_requester: RTL and testbench

//  APB initiator (requester) driving psel/penable/pwrite/paddr/pwdata and sampling pready/prdata.

---
 rtl/apb_requester.sv | 101 ++++++++++
 tb/tb_apb_requester.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_requester.sv
// rtl/apb_requester.sv - APB requester: one valid/ready command in, one APB transfer and one response out
module apb_requester #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              prst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TO_EN = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             accept, done, abort;

  assign cmd_ready = (state == IDLE) && prst;
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    state_nxt = state;
    psel      = 1'b0;
    penable   = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = SETUP;
      end
      SETUP: begin
        psel      = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (pready) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (TO_EN && (wait_cnt == CNT_LAST)) begin
          // wait_cnt counts completed not-ready ACCESS cycles, so this is the TIMEOUT-th one
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!prst) begin
      state       <= IDLE;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      wait_cnt    <= '0;
      rsp_valid   <= 1'b0;
      rsp_write   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      state     <= state_nxt;
      rsp_valid <= done || abort;
      if (accept) begin
        pwrite   <= cmd_write;
        paddr    <= cmd_addr;
        pwdata   <= cmd_write ? cmd_wdata : '0;
        wait_cnt <= '0;
      end else if ((state == ACCESS) && !pready) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      // response fields only change on a completion and otherwise hold
      if (done || abort) begin
        rsp_write   <= pwrite;
        rsp_timeout <= abort;
        rsp_rdata   <= (done && !pwrite) ? prdata : '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_requester.sv
// tb/tb_apb_requester.sv - self-checking bench for apb_requester with a wait-state APB completer model
module tb_apb_requester;

  localparam int TIMEOUT = 16;

  logic       pclk = 1'b0;
  logic       prst = 1'b0;
  logic       cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [7:0] cmd_addr = '0, cmd_wdata = '0;
  logic       cmd_ready, rsp_valid, rsp_write, rsp_timeout;
  logic [7:0] rsp_rdata;
  logic       psel, penable, pwrite, pready;
  logic [7:0] paddr, pwdata, prdata;

  always #5 pclk = ~pclk;

  apb_requester #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TIMEOUT)) dut (
    .pclk(pclk), .prst(prst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .prdata(prdata)
  );

  // completer: raises pready after wait_need not-ready ACCESS cycles
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  int acc_cyc = 0;
  int wait_need = 0;

  assign pready = psel && penable && (acc_cyc >= wait_need);
  assign prdata = pready ? mem[paddr] : 8'hEE;

  always @(posedge pclk) begin
    if (psel && penable && !pready) acc_cyc <= acc_cyc + 1;
    else acc_cyc <= 0;
    if (psel && penable && pready && pwrite) mem[paddr] <= pwdata;
  end

  int checks = 0;
  int errors = 0;
  logic bus_ok;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // reference: transfer times out iff the completer needs TIMEOUT or more wait cycles
  function automatic void model_apply(input bit wr, input logic [7:0] a, input logic [7:0] d,
                                      input int w, output logic [7:0] er, output bit eto,
                                      output int elat);
    eto  = (w >= TIMEOUT);
    elat = 2 + (eto ? TIMEOUT - 1 : w);
    er   = (wr || eto) ? 8'h00 : ref_mem[a];
    if (wr && !eto) ref_mem[a] = d;
  endfunction

  task automatic check_bus(input bit wr, input logic [7:0] a, input logic [7:0] d, input bit en);
    if (psel !== 1'b1 || penable !== en || paddr !== a || pwrite !== wr ||
        pwdata !== (wr ? d : 8'h00) || cmd_ready !== 1'b0) bus_ok = 1'b0;
  endtask

  task automatic do_cmd(input bit wr, input logic [7:0] a, input logic [7:0] d, input int w,
                        input logic [7:0] er, input bit eto, input int elat, input string tag);
    int n;
    int lat;
    wait_need = w;
    cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin @(posedge pclk); #1; n++; end
    if (!cmd_ready) begin
      chk({tag, "_accept"}, 32'd0, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge pclk); #1;
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom); cmd_addr = 8'($urandom); cmd_wdata = 8'($urandom);
    bus_ok = 1'b1;
    check_bus(wr, a, d, 1'b0);
    lat = 0;
    do begin
      @(posedge pclk); #1;
      lat++;
      if (!rsp_valid) check_bus(wr, a, d, 1'b1);
    end while (!rsp_valid && lat < 40);
    chk({tag, "_rsp_valid"}, rsp_valid, 1);
    if (psel !== 1'b0 || penable !== 1'b0) bus_ok = 1'b0;
    chk({tag, "_bus"}, bus_ok, 1);
    chk({tag, "_latency"}, lat, elat);
    chk({tag, "_rsp_write"}, rsp_write, wr);
    chk({tag, "_rsp_rdata"}, rsp_rdata, er);
    chk({tag, "_rsp_timeout"}, rsp_timeout, eto);
    @(posedge pclk); #1;
    chk({tag, "_pulse"}, rsp_valid, 0);
    chk({tag, "_hold"}, rsp_rdata, er);
  endtask

  typedef struct {
    bit         wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         wt;
    logic [7:0] exp_rdata;
    bit         exp_to;
    int         exp_lat;
  } vec_t;

  vec_t tbl [8];
  logic [7:0] b_addr [3];
  logic [7:0] pool [4];

  initial begin
    logic [7:0] er;
    bit eto;
    int elat, idx, rsp_cnt, last_acc, gap_bad, busy_bad, n;
    bit ready_now;

    tbl[0] = '{1'b1, 8'h3C, 8'hA5, 0,  8'h00, 1'b0, 2};
    tbl[1] = '{1'b0, 8'h3C, 8'h00, 0,  8'hA5, 1'b0, 2};
    tbl[2] = '{1'b0, 8'h3C, 8'h00, 5,  8'hA5, 1'b0, 7};
    tbl[3] = '{1'b0, 8'h3C, 8'h00, 30, 8'h00, 1'b1, 17};
    tbl[4] = '{1'b1, 8'h3C, 8'h5A, 16, 8'h00, 1'b1, 17};
    tbl[5] = '{1'b0, 8'h3C, 8'h00, 15, 8'hA5, 1'b0, 17};
    tbl[6] = '{1'b1, 8'h7F, 8'hC3, 1,  8'h00, 1'b0, 3};
    tbl[7] = '{1'b0, 8'h7F, 8'h00, 2,  8'hC3, 1'b0, 4};
    b_addr = '{8'h00, 8'hFF, 8'h80};
    pool   = '{8'h3C, 8'h7F, 8'h00, 8'hFF};
    for (int i = 0; i < 256; i++) begin mem[i] = 8'h00; ref_mem[i] = 8'h00; end

    repeat (3) @(posedge pclk);
    #1;
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_write", rsp_write, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    prst = 1'b1;
    #1;
    chk("rst_cmd_ready_rel", cmd_ready, 1);
    @(posedge pclk); #1;

    for (int i = 0; i < 8; i++) begin
      model_apply(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].wt, er, eto, elat);
      do_cmd(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].wt,
             tbl[i].exp_rdata, tbl[i].exp_to, tbl[i].exp_lat, $sformatf("vec%0d", i));
    end

    // three writes with cmd_valid held high throughout
    wait_need = 0;
    idx = 0; rsp_cnt = 0; last_acc = -1; gap_bad = 0; busy_bad = 0;
    cmd_write = 1'b1; cmd_addr = b_addr[0]; cmd_wdata = 8'h10; cmd_valid = 1'b1;
    for (int cyc = 0; cyc < 40 && !(idx == 3 && rsp_cnt == 3); cyc++) begin
      ready_now = cmd_ready && cmd_valid;
      @(posedge pclk); #1;
      if (ready_now) begin
        if (last_acc >= 0 && cyc - last_acc != 3) gap_bad++;
        last_acc = cyc;
        model_apply(1'b1, b_addr[idx], 8'(8'h10 + idx), 0, er, eto, elat);
        idx++;
        if (idx < 3) begin cmd_addr = b_addr[idx]; cmd_wdata = 8'(8'h10 + idx); end
        else cmd_valid = 1'b0;
      end
      if (rsp_valid) rsp_cnt++;
      if (psel && cmd_ready) busy_bad++;
    end
    cmd_valid = 1'b0;
    chk("b2b_accepts", idx, 3);
    chk("b2b_rsp_count", rsp_cnt, 3);
    chk("b2b_gap", gap_bad, 0);
    chk("b2b_busy_ready", busy_bad, 0);
    @(posedge pclk); #1;

    // reset while stalled in ACCESS
    wait_need = 100;
    cmd_write = 1'b0; cmd_addr = 8'h3C; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin @(posedge pclk); #1; n++; end
    chk("mid_accept", cmd_ready, 1);
    @(posedge pclk); #1;
    cmd_valid = 1'b0;
    repeat (3) begin @(posedge pclk); #1; end
    chk("mid_in_access", {psel, penable}, 2'b11);
    prst = 1'b0;
    @(posedge pclk); #1;
    chk("mid_psel", psel, 0);
    chk("mid_penable", penable, 0);
    chk("mid_rsp_valid", rsp_valid, 0);
    chk("mid_cmd_ready_rst", cmd_ready, 0);
    chk("mid_paddr", paddr, 0);
    prst = 1'b1;
    #1;
    chk("mid_cmd_ready", cmd_ready, 1);
    n = 0;
    repeat (6) begin @(posedge pclk); #1; if (rsp_valid) n++; end
    chk("mid_no_rsp", n, 0);
    wait_need = 0;

    for (int i = 0; i < 40; i++) begin
      bit wr;
      logic [7:0] a, d;
      int r, w;
      wr = 1'($urandom);
      a  = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 3)] : 8'($urandom);
      d  = 8'($urandom);
      r  = int'($urandom_range(0, 9));
      w  = (r == 9) ? TIMEOUT + int'($urandom_range(0, 3)) :
           (r == 8) ? TIMEOUT - 1 : int'($urandom_range(0, 4));
      model_apply(wr, a, d, w, er, eto, elat);
      do_cmd(wr, a, d, w, er, eto, elat, $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
